// File: rtl/enum_job_sequencer.sv
// Job controller: accepts start/len, walks IDLE -> RUNNING -> DONE, reports level and status enums.
// Optional stall input enabled by defining ENUM_JOB_STALL_EN.
module enum_job_sequencer #(
    parameter int CNT_W       = 8,
    parameter int WARN_THRESH = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             abort_i,
`ifdef ENUM_JOB_STALL_EN
    input  logic             stall_i,
`endif
    output logic [1:0]       state_o,
    output logic [1:0]       level_o,
    output logic [31:0]      status_o,
    output logic [CNT_W-1:0] remaining_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LV_OFF  = 2'd0,
        LV_LOW  = 2'd1,
        LV_MED  = 2'd2,
        LV_HIGH = 2'd3
    } level_t;

    typedef enum int {
        STS_ERR  = -32'sd1,
        STS_OK   = 32'sd0,
        STS_WARN = 32'sd1
    } status_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Level follows the two most significant bits of the remaining count.
    function automatic level_t level_of(input logic [1:0] top);
        level_t lv;
        case (top)
            2'b11:   lv = LV_HIGH;
            2'b10:   lv = LV_MED;
            default: lv = LV_LOW;
        endcase
        return lv;
    endfunction

    state_t           state_q, state_d;
    level_t           level_q, level_d;
    status_t          status_q, status_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             stall_s;
    logic             len_warn_s;

`ifdef ENUM_JOB_STALL_EN
    assign stall_s = stall_i;
`else
    assign stall_s = 1'b0;
`endif

    assign len_warn_s = (32'(len_i) >= 32'(WARN_THRESH));

    // Next-state, counter and status computation.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        status_d    = status_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i == CNT_ZERO) begin
                        state_d     = ST_DONE;
                        status_d    = STS_ERR;
                        remaining_d = CNT_ZERO;
                    end else begin
                        state_d     = ST_RUNNING;
                        remaining_d = len_i;
                        status_d    = len_warn_s ? STS_WARN : STS_OK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                // Abort takes priority over both stall and the final decrement.
                if (abort_i) begin
                    state_d     = ST_DONE;
                    status_d    = STS_ERR;
                    remaining_d = CNT_ZERO;
                end else if (stall_s) begin
                    remaining_d = remaining_q;
                end else if (remaining_q == CNT_ONE) begin
                    state_d     = ST_DONE;
                    remaining_d = CNT_ZERO;
                end else begin
                    remaining_d = remaining_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                remaining_d = CNT_ZERO;
            end
        endcase
    end

    // Output flags are precomputed from next state so every output is a flop.
    always_comb begin
        busy_d  = (state_d == ST_RUNNING);
        done_d  = (state_d == ST_DONE);
        level_d = LV_OFF;
        if (busy_d) begin
            level_d = level_of(remaining_d[CNT_W-1 -: 2]);
        end else begin
            level_d = LV_OFF;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= CNT_ZERO;
            status_q    <= STS_OK;
            level_q     <= LV_OFF;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            status_q    <= status_d;
            level_q     <= level_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign state_o     = state_q;
    assign level_o     = level_q;
    assign status_o    = status_q;
    assign remaining_o = remaining_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
